deser_frame_align: RTL and testbench

DESER_FRAME_ALIGN -- requirements
Module: deser_frame_align

---
 rtl/deser_pkg.sv | 31 +++
 rtl/deser_lane.sv | 42 ++++
 rtl/deser_frame_align.sv | 263 ++++++++++++++++++++++++++
 tb/tb_deser_frame_align.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared types and width helpers for the deserialiser / frame aligner.
//   deser_state_t : alignment FSM state encoding
//   slip_cnt_w()  : width of a counter able to hold 0..data_width
//   run_cnt_w()   : width of a run counter able to hold 0..max_count
//   ERR_COUNT_W   : width of the optional locked-error statistics counter
// -----------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } deser_state_t;

    localparam int ERR_COUNT_W = 16;

    // One bit more than $clog2 so the per-attempt slip tally can reach
    // data_width itself (the "all rotations tried" condition).
    function automatic int slip_cnt_w(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

    function automatic int run_cnt_w(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/deser_lane.sv
// -----------------------------------------------------------------------------
// deser_lane
// One serial lane: shift register plus word register. Counting and slipping
// are done centrally so every lane sees identical strobes and word boundaries.
// Ports:
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   shift_en  : capture bit_in this cycle
//   word_en   : bit_in is the last bit of a word; load the word register
//   bit_in    : serial bit for this lane
//   word      : last completed word, first received bit in bit 0
// -----------------------------------------------------------------------------
module deser_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic                  word_en,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] word
);

    // Only DATA_WIDTH-1 bits are stored; the last bit goes straight into the
    // word register, so the word is complete on the same edge.
    logic [DATA_WIDTH-2:0] shift_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            word    <= '0;
        end else begin
            if (shift_en) begin
                shift_q <= {bit_in, shift_q[DATA_WIDTH-2:1]};
            end
            if (word_en) begin
                word <= {bit_in, shift_q};
            end
        end
    end

endmodule

// File: rtl/deser_frame_align.sv
// -----------------------------------------------------------------------------
// deser_frame_align
// Multi-lane deserialiser with frame-lane word alignment. All lanes and the
// frame lane share one bit counter; a slip discards the next valid bit on all
// lanes, moving the word boundary one bit later. The FSM slips until the frame
// lane shows FRAME_PATTERN for MATCH_WORDS consecutive words.
//
// Optional build macro: DESER_STATS_EN adds err_count, a saturating count of
// mismatched frame words seen while locked (cleared by reset / align_start).
//
// Ports:
//   clk         : clock
//   rst_n       : synchronous active-low reset
//   din         : one serial bit per data lane
//   frame_in    : frame-lane serial bit
//   bit_valid   : qualifies din / frame_in
//   align_start : pulse, starts (or restarts) automatic alignment
//   bitslip     : pulse, manual slip (honoured in IDLE only)
//   dout        : lane k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   dout_valid  : one-cycle pulse per completed word
//   aligned     : frame lane locked
//   align_fail  : every rotation tried without lock
//   slip_count  : slips applied, wraps after DATA_WIDTH-1
//   err_count   : (DESER_STATS_EN only) locked frame mismatches
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset; manual bitslip accepted
// SETTLE | discarding SETTLE_WORDS words after a slip / attempt start
// CHECK  | counting consecutive frame-pattern matches
// LOCKED | aligned; counting consecutive mismatches toward loss of lock
// FAIL   | all DATA_WIDTH slips tried; wait for align_start
// -----------------------------------------------------------------------------
module deser_frame_align
    import deser_pkg::*;
#(
    parameter int                    LANES         = 4,
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
    parameter int                    MATCH_WORDS   = 4,
    parameter int                    LOSS_WORDS    = 4,
    parameter int                    SETTLE_WORDS  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [LANES-1:0]                    din,
    input  logic                                frame_in,
    input  logic                                bit_valid,
    input  logic                                align_start,
    input  logic                                bitslip,
    output logic [LANES*DATA_WIDTH-1:0]         dout,
    output logic                                dout_valid,
    output logic                                aligned,
    output logic                                align_fail,
    output logic [slip_cnt_w(DATA_WIDTH)-1:0]   slip_count
`ifdef DESER_STATS_EN
    ,
    output logic [ERR_COUNT_W-1:0]              err_count
`endif
);

    localparam int BCW  = $clog2(DATA_WIDTH);
    localparam int SCW  = slip_cnt_w(DATA_WIDTH);
    localparam int SETW = run_cnt_w(SETTLE_WORDS);
    localparam int MW   = run_cnt_w(MATCH_WORDS);
    localparam int LW   = run_cnt_w(LOSS_WORDS);

    localparam logic [BCW-1:0]  BIT_LAST    = BCW'(DATA_WIDTH - 1);
    localparam logic [SCW-1:0]  SLIP_LAST   = SCW'(DATA_WIDTH - 1);
    localparam logic [SCW-1:0]  SLIP_MAX    = SCW'(DATA_WIDTH);
    localparam logic [SETW-1:0] SETTLE_LAST = SETW'(SETTLE_WORDS - 1);
    localparam logic [MW-1:0]   MATCH_LAST  = MW'(MATCH_WORDS - 1);
    localparam logic [LW-1:0]   LOSS_LAST   = LW'(LOSS_WORDS - 1);

    // ---------------------------------------------------------------- datapath
    logic [BCW-1:0]        bit_cnt_q;
    logic                  slip_pend_q;
    logic                  slip_pend_d;
    logic                  shift_en;
    logic                  word_en;
    logic [DATA_WIDTH-1:0] frame_word;
    logic                  frame_ok;

    // A pending slip swallows the next valid bit: nothing shifts and the
    // counter holds, so the boundary moves one bit later.
    assign shift_en = bit_valid && !slip_pend_q;
    assign word_en  = shift_en && (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= word_en;
            if (shift_en) begin
                bit_cnt_q <= (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BCW'(1);
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        deser_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .shift_en (shift_en),
            .word_en  (word_en),
            .bit_in   (din[k]),
            .word     (dout[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    deser_lane #(.DATA_WIDTH(DATA_WIDTH)) u_frame_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .word_en  (word_en),
        .bit_in   (frame_in),
        .word     (frame_word)
    );

    // frame_word is valid in the same cycle dout_valid pulses.
    assign frame_ok = (frame_word == FRAME_PATTERN);

    // --------------------------------------------------------------------- FSM
    deser_state_t    state_q,      state_d;
    logic [SETW-1:0] settle_q,     settle_d;
    logic [MW-1:0]   match_q,      match_d;
    logic [LW-1:0]   loss_q,       loss_d;
    logic [SCW-1:0]  attempt_q,    attempt_d;
    logic [SCW-1:0]  slip_count_q, slip_count_d;
    logic            slip_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            match_q      <= '0;
            loss_q       <= '0;
            attempt_q    <= '0;
            slip_count_q <= '0;
            slip_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            match_q      <= match_d;
            loss_q       <= loss_d;
            attempt_q    <= attempt_d;
            slip_count_q <= slip_count_d;
            slip_pend_q  <= slip_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        match_d      = match_q;
        loss_d       = loss_q;
        attempt_d    = attempt_q;
        slip_count_d = slip_count_q;
        slip_req     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bitslip) begin
                    slip_req = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (dout_valid) begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = ST_CHECK;
                    end else begin
                        settle_d = settle_q + SETW'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (dout_valid) begin
                    if (frame_ok) begin
                        if (match_q == MATCH_LAST) begin
                            match_d = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                        if (attempt_q == SLIP_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            slip_req  = 1'b1;
                            attempt_d = attempt_q + SCW'(1);
                            state_d   = ST_SETTLE;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (dout_valid) begin
                    if (frame_ok) begin
                        loss_d = '0;
                    end else if (loss_q == LOSS_LAST) begin
                        // New attempt from the current boundary, no slip yet.
                        loss_d    = '0;
                        attempt_d = '0;
                        state_d   = ST_SETTLE;
                    end else begin
                        loss_d = loss_q + LW'(1);
                    end
                end
            end
            ST_FAIL: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // align_start overrides everything, including a same-cycle bitslip.
        if (align_start) begin
            state_d   = ST_SETTLE;
            settle_d  = '0;
            match_d   = '0;
            loss_d    = '0;
            attempt_d = '0;
            slip_req  = 1'b0;
        end

        if (align_start) begin
            slip_count_d = '0;
        end else if (slip_req) begin
            slip_count_d = (slip_count_q == SLIP_LAST) ? '0 : slip_count_q + SCW'(1);
        end

        // A pending slip is consumed by the next valid bit; a restart drops it.
        slip_pend_d = slip_pend_q && !bit_valid;
        if (slip_req) begin
            slip_pend_d = 1'b1;
        end
        if (align_start) begin
            slip_pend_d = 1'b0;
        end
    end

    assign aligned    = (state_q == ST_LOCKED);
    assign align_fail = (state_q == ST_FAIL);
    assign slip_count = slip_count_q;

`ifdef DESER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (align_start) begin
            err_count <= '0;
        end else if ((state_q == ST_LOCKED) && dout_valid && !frame_ok &&
                     (err_count != {ERR_COUNT_W{1'b1}})) begin
            err_count <= err_count + ERR_COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_deser_frame_align.sv
module tb_deser_frame_align;

    localparam int LANES = 4;
    localparam int DW    = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [LANES-1:0]      din;
    logic                  frame_in;
    logic                  bit_valid;
    logic                  align_start;
    logic                  bitslip;
    logic [LANES*DW-1:0]   dout;
    logic                  dout_valid;
    logic                  aligned;
    logic                  align_fail;
    logic [3:0]            slip_count;
`ifdef DESER_STATS_EN
    logic [15:0]           err_count;
`endif

    int         checks = 0;
    int         failures = 0;
    int         pos, off, gap, bad_lo, bad_hi, chk_data;
    int         dv_err, dv_pulses, max_slip, rst_bad;
    bit         dv_track, saw_unal, ok;
    logic [7:0] cur_frame;

    always #5 clk = ~clk;

    deser_frame_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .frame_in    (frame_in),
        .bit_valid   (bit_valid),
        .align_start (align_start),
        .bitslip     (bitslip),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .aligned     (aligned),
        .align_fail  (align_fail),
        .slip_count  (slip_count)
`ifdef DESER_STATS_EN
        ,
        .err_count   (err_count)
`endif
    );

    function automatic logic [7:0] data_word(input int k, input int w);
        return 8'((w * 37 + k * 11 + 5) & 255);
    endfunction

    // Sender word index / bit index of stream position p (words start at off).
    function automatic int word_idx(input int p);
        return (p + 64 - off) / 8 - 8;
    endfunction

    function automatic int bit_idx(input int p);
        return (p + 64 - off) % 8;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor(input bit was_valid);
        logic [LANES*DW-1:0] exp;
        int w;
        if (aligned !== 1'b1) saw_unal = 1'b1;
        if (int'(slip_count) > max_slip) max_slip = int'(slip_count);
        if (dv_track) begin
            if (dout_valid === 1'b1) dv_pulses++;
            if (dout_valid !== (was_valid && (pos % 8 == 7))) dv_err++;
        end
        if (was_valid && chk_data > 0 && dout_valid === 1'b1) begin
            w = word_idx(pos);
            for (int k = 0; k < LANES; k++) exp[k*DW +: DW] = data_word(k, w);
            check("word_boundary", 64'(bit_idx(pos)), 64'd7);
            check("lane_data", 64'(dout), 64'(exp));
            chk_data--;
        end
    endtask

    task automatic send_one(input bit a_s, input bit b_s);
        int w, b;
        logic [7:0] fw, dwv;
        w  = word_idx(pos);
        b  = bit_idx(pos);
        fw = (w >= bad_lo && w < bad_hi) ? 8'h00 : cur_frame;
        frame_in = fw[b];
        for (int k = 0; k < LANES; k++) begin
            dwv = data_word(k, w);
            din[k] = dwv[b];
        end
        bit_valid   = 1'b1;
        align_start = a_s;
        bitslip     = b_s;
        @(posedge clk); #1;
        monitor(1'b1);
        pos++;
        bit_valid   = 1'b0;
        align_start = 1'b0;
        bitslip     = 1'b0;
        for (int g = 0; g < gap; g++) begin
            din      = LANES'($urandom);
            frame_in = 1'($urandom);
            @(posedge clk); #1;
            monitor(1'b0);
        end
    endtask

    // sel 0 watches aligned, sel 1 watches align_fail.
    task automatic run_until(input int sel, input logic target, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            send_one(1'b0, 1'b0);
            if (sel == 0 ? (aligned === target) : (align_fail === target)) hit = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bit_valid   = 1'b0;
        align_start = 1'b0;
        bitslip     = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n  = 1'b1;
        pos    = 0;
        bad_lo = -100;
        bad_hi = -100;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; frame_in = 1'b0; bit_valid = 1'b0;
        align_start = 1'b0; bitslip = 1'b0;
        pos = 0; off = 0; gap = 0; bad_lo = -100; bad_hi = -100; chk_data = 0;
        dv_err = 0; dv_pulses = 0; max_slip = 0; rst_bad = 0;
        dv_track = 1'b0; saw_unal = 1'b0; cur_frame = 8'hF0;

        // Reset held with random activity on the inputs.
        repeat (20) begin
            din = LANES'($urandom); frame_in = 1'($urandom);
            bit_valid = 1'($urandom); bitslip = 1'($urandom); align_start = 1'($urandom);
            @(posedge clk); #1;
            if (dout !== '0 || dout_valid !== 1'b0 || aligned !== 1'b0 ||
                align_fail !== 1'b0 || slip_count !== 4'd0) rst_bad++;
        end
        check("reset_hold", 64'(rst_bad), 64'd0);
        bit_valid = 1'b0; bitslip = 1'b0; align_start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_aligned", 64'(aligned), 64'd0);
        check("rst_align_fail", 64'(align_fail), 64'd0);
        check("rst_slip_count", 64'(slip_count), 64'd0);

        // bit_valid every 3rd cycle: one dout_valid per 8 valid bits.
        pos = 0; off = 0; gap = 2; dv_track = 1'b1; chk_data = 2;
        repeat (40) send_one(1'b0, 1'b0);
        dv_track = 1'b0; gap = 0;
        check("gapped_dv_timing", 64'(dv_err), 64'd0);
        check("gapped_dv_count", 64'(dv_pulses), 64'd5);

        // Frame 0xF0 with a 3-bit offset locks after three slips.
        do_reset();
        off = 3; cur_frame = 8'hF0;
        repeat (16) send_one(1'b0, 1'b0);
        send_one(1'b1, 1'b0);
        run_until(0, 1'b1, 1000, ok);
        check("lock_reached", 64'(ok), 64'd1);
        check("lock_slip_count", 64'(slip_count), 64'd3);
        check("lock_no_fail", 64'(align_fail), 64'd0);
        chk_data = 3;
        repeat (40) send_one(1'b0, 1'b0);
        check("data_words_seen", 64'(chk_data), 64'd0);

        // Three bad frame words keep lock, four drop it.
        saw_unal = 1'b0;
        bad_lo = word_idx(pos) + 2; bad_hi = bad_lo + 3;
        repeat (64) send_one(1'b0, 1'b0);
        check("lock_kept_3bad", 64'(saw_unal), 64'd0);
        bad_lo = word_idx(pos) + 2; bad_hi = bad_lo + 4;
        run_until(0, 1'b0, 120, ok);
        check("lock_lost_4bad", 64'(ok), 64'd1);
        check("drop_after_4th", 64'(word_idx(pos - 2)), 64'(bad_hi - 1));
`ifdef DESER_STATS_EN
        check("err_count", 64'(err_count), 64'd7);
`endif
        run_until(0, 1'b1, 200, ok);
        check("relock", 64'(ok), 64'd1);
        check("relock_slip_count", 64'(slip_count), 64'd3);

        // Constant 0x00 frame exhausts all rotations.
        do_reset();
        off = 0; cur_frame = 8'h00; max_slip = 0;
        send_one(1'b1, 1'b0);
        run_until(1, 1'b1, 1000, ok);
        check("fail_reached", 64'(ok), 64'd1);
        check("fail_aligned", 64'(aligned), 64'd0);
        check("fail_slip_wrap", 64'(slip_count), 64'd0);
        check("fail_max_slip", 64'(max_slip), 64'd7);
        off = 5; cur_frame = 8'hF0;
        send_one(1'b1, 1'b0);
        check("fail_cleared", 64'(align_fail), 64'd0);
        run_until(0, 1'b1, 1000, ok);
        check("recover_lock", 64'(ok), 64'd1);
        check("recover_slip_count", 64'(slip_count), 64'd5);

        // Pending slip dropped by reset; align_start beats bitslip.
        do_reset();
        bitslip = 1'b1;
        @(posedge clk); #1;
        bitslip = 1'b0;
        do_reset();
        off = 2;
        repeat (12) send_one(1'b0, 1'b0);
        send_one(1'b1, 1'b1);
        check("start_beats_slip", 64'(slip_count), 64'd0);
        run_until(0, 1'b1, 1000, ok);
        check("start_slip_lock", 64'(ok), 64'd1);
        check("start_slip_count", 64'(slip_count), 64'd2);

        // Manual bitslip in IDLE, then ignored once locked.
        do_reset();
        off = 1;
        repeat (10) send_one(1'b0, 1'b0);
        send_one(1'b0, 1'b1);
        check("manual_slip", 64'(slip_count), 64'd1);
        repeat (20) send_one(1'b0, 1'b0);
        send_one(1'b1, 1'b0);
        run_until(0, 1'b1, 1000, ok);
        check("manual_lock", 64'(ok), 64'd1);
        check("manual_lock_slips", 64'(slip_count), 64'd0);
        saw_unal = 1'b0;
        send_one(1'b0, 1'b1);
        repeat (40) send_one(1'b0, 1'b0);
        check("slip_ignored_locked", 64'(saw_unal), 64'd0);
        check("slip_ignored_count", 64'(slip_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
